err_event_arb: RTL

ERR_EVENT_ARB -- requirements
Module: err_event_arb

---
 rtl/err_evt_pkg.sv | 23 ++
 rtl/err_sat_cnt.sv | 31 +++
 rtl/err_event_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/err_evt_pkg.sv
// Shared types for the error-event arbiter: source ids and the pending-slot record.
package err_evt_pkg;

  localparam int unsigned NUM_SRC     = 3;
  localparam int unsigned POS_W       = 8;
  // Slot address storage is sized for the widest supported ADDR_WIDTH.
  localparam int unsigned SLOT_ADDR_W = 64;

  typedef enum logic [1:0] {
    SRC_ECC = 2'd0,
    SRC_CRC = 2'd1,
    SRC_PAR = 2'd2
  } src_e;

  typedef struct packed {
    logic                   vld;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [POS_W-1:0]       pos;
    logic                   sbe;
    logic                   dbe;
  } slot_t;

endpackage

// File: rtl/err_sat_cnt.sv
// Saturating up-counter with a synchronous clear; an increment in the clear cycle still lands.
module err_sat_cnt #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;

  // Next value: clear selects a zero base, carry-out means saturate.
  always_comb begin
    base = clr ? '0 : cnt;
    sum  = {1'b0, base} + (WIDTH+1)'(inc);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/err_event_arb.sv
// Collects ECC/CRC/parity error pulses into one slot per source and emits them
// one at a time in round-robin order, with per-source and dropped-event counters.
module err_event_arb
  import err_evt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cnt_clr,
  input  logic                  ecc_evt,
  input  logic                  ecc_sbe,
  input  logic                  ecc_dbe,
  input  logic [ADDR_WIDTH-1:0] ecc_addr,
  input  logic [7:0]            ecc_pos,
  input  logic                  crc_evt,
  input  logic [ADDR_WIDTH-1:0] crc_addr,
  input  logic                  par_evt,
  input  logic [ADDR_WIDTH-1:0] par_addr,
  output logic                  out_ecc_err,
  output logic                  out_crc_err,
  output logic                  out_par_err,
  output logic                  out_ecc_sbe,
  output logic                  out_ecc_dbe,
  output logic [CNT_WIDTH-1:0]  out_ecc_cnt,
  output logic [CNT_WIDTH-1:0]  out_crc_cnt,
  output logic [CNT_WIDTH-1:0]  out_par_cnt,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_pos,
  output logic [2:0]            pending,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  slot_t              slot_q   [NUM_SRC];
  slot_t              slot_d   [NUM_SRC];
  slot_t              new_slot [NUM_SRC];
  src_e               rr_q, rr_d;
  src_e               gnt_src;
  logic               gnt_vld;
  logic [NUM_SRC-1:0] evt, gnt, drop;
  logic [2:0]         rr_sum;
  logic [1:0]         idx;
  logic [1:0]         drop_num, drop_inc;

  // Qualified events and the slot records they would load.
  always_comb begin
    evt = {par_evt, crc_evt, ecc_evt} & {NUM_SRC{en}};
    new_slot[SRC_ECC] = '{vld: 1'b1, addr: SLOT_ADDR_W'(ecc_addr), pos: ecc_pos,
                          sbe: ecc_sbe, dbe: ecc_dbe};
    new_slot[SRC_CRC] = '{vld: 1'b1, addr: SLOT_ADDR_W'(crc_addr), pos: 8'h00,
                          sbe: 1'b0, dbe: 1'b0};
    new_slot[SRC_PAR] = '{vld: 1'b1, addr: SLOT_ADDR_W'(par_addr), pos: 8'h00,
                          sbe: 1'b0, dbe: 1'b0};
  end

  // Round-robin grant, slot capture/drop and pointer advance.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = rr_q;
    gnt     = '0;
    rr_d    = rr_q;
    rr_sum  = '0;
    idx     = '0;
    drop    = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      rr_sum = 3'(rr_q) + 3'(k);
      idx    = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
      if (en && !gnt_vld && slot_q[idx].vld) begin
        gnt_vld = 1'b1;
        gnt_src = src_e'(idx);
      end
    end
    if (gnt_vld) begin
      gnt[gnt_src] = 1'b1;
      rr_d = (gnt_src == SRC_PAR) ? SRC_ECC : src_e'(2'(gnt_src) + 2'd1);
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      slot_d[i] = slot_q[i];
      if (evt[i]) begin
        if (!slot_q[i].vld || gnt[i]) slot_d[i] = new_slot[i];
        else                          drop[i]   = 1'b1;
      end else if (gnt[i]) begin
        slot_d[i].vld = 1'b0;
      end
    end
    drop_num = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    drop_inc = cnt_clr ? 2'd0 : drop_num;
  end

  // Slot, pointer and emission registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) slot_q[i] <= '0;
      rr_q        <= SRC_ECC;
      out_ecc_err <= 1'b0;
      out_crc_err <= 1'b0;
      out_par_err <= 1'b0;
      out_ecc_sbe <= 1'b0;
      out_ecc_dbe <= 1'b0;
      out_addr    <= '0;
      out_pos     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) slot_q[i] <= slot_d[i];
      rr_q        <= rr_d;
      out_ecc_err <= gnt[SRC_ECC];
      out_crc_err <= gnt[SRC_CRC];
      out_par_err <= gnt[SRC_PAR];
      out_ecc_sbe <= gnt[SRC_ECC] & slot_q[SRC_ECC].sbe;
      out_ecc_dbe <= gnt[SRC_ECC] & slot_q[SRC_ECC].dbe;
      if (gnt_vld) begin
        out_addr <= ADDR_WIDTH'(slot_q[gnt_src].addr);
        out_pos  <= slot_q[gnt_src].pos;
      end
    end
  end

  assign pending = {slot_q[SRC_PAR].vld, slot_q[SRC_CRC].vld, slot_q[SRC_ECC].vld};

  err_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_ecc_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(evt[SRC_ECC]), .cnt(out_ecc_cnt)
  );

  err_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_crc_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(evt[SRC_CRC]), .cnt(out_crc_cnt)
  );

  err_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_par_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(evt[SRC_PAR]), .cnt(out_par_cnt)
  );

  err_sat_cnt #(.WIDTH(DROP_WIDTH), .INC_W(2)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(drop_inc), .cnt(drop_cnt)
  );

endmodule
